// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
// Segment patterns here are active-high; display polarity is applied in the top.
package seg7_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Bit 0 = segment a ... bit 6 = segment g; 'b' and 'd' are lower-case glyphs.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return HEX_SEG[hex];
    endfunction

    // Digit index width; a single-digit display still needs one bit.
    function automatic int unsigned idx_width(input int unsigned digits);
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern (bit 0 = a).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_n.sv
// Multiplexed DIGITS-wide seven-segment scanner with prescaler, frame-latched shadow
// inputs, leading-zero blanking, per-slot anti-ghost blanking and configurable polarity.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned CLK_DIV        = 40000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          CAT_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lzb,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            cat,
    output logic                  frame
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = idx_width(DIGITS);
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? '1 : '0;
    localparam logic [7:0]        CAT_OFF = CAT_ACTIVE_LOW ? '1 : '0;

    if (DIGITS < 1 || DIGITS > 16 || CLK_DIV < 2 || BLANK_CYCLES >= CLK_DIV) begin : g_param_check
        $error("seg7_scan_n: illegal DIGITS/CLK_DIV/BLANK_CYCLES combination");
    end

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    logic                last_slot;
    logic [4*DIGITS-1:0] sh_value;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_en;
    logic                sh_lzb;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_en;
    logic                cur_lz;
    logic [DIGITS-1:0]   lz;
    logic [DIGITS-1:0]   sel;
    logic [6:0]          dec_seg;
    logic [7:0]          seg_hi;

    assign tick      = (cnt == CNT_W'(CLK_DIV - 1));
    assign last_slot = (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= last_slot ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Inputs are sampled only at the frame boundary so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            sh_lzb   <= 1'b0;
            frame    <= 1'b0;
        end else begin
            frame <= tick && last_slot;
            if (tick && last_slot) begin
                sh_value <= value;
                sh_dp    <= dp;
                sh_en    <= digit_en;
                sh_lzb   <= lzb;
            end
        end
    end

    // lz[i] is set when nibble i and every more-significant nibble are zero.
    always_comb begin
        lz = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            for (int unsigned j = 0; j < DIGITS; j++) begin
                if (j >= i && sh_value[4*j +: 4] != 4'h0) begin
                    lz[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        sel     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = sh_value[4*i +: 4];
                cur_dp  = sh_dp[i];
                cur_en  = sh_en[i];
                cur_lz  = lz[i] && (i != 0);
                sel[i]  = 1'b1;
            end
        end
    end

    seg7_hex_decode u_dec (
        .hex (cur_nib),
        .seg (dec_seg)
    );

    always_comb begin
        seg_hi         = '0;
        seg_hi[6:0]    = dec_seg;
        seg_hi[SEG_DP] = cur_dp;
        if (!cur_en) begin
            seg_hi = '0;
        end else if (sh_lzb && cur_lz) begin
            seg_hi[6:0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            cat <= CAT_OFF;
        end else if (cnt < CNT_W'(BLANK_CYCLES)) begin
            an  <= AN_OFF;
            cat <= CAT_OFF;
        end else begin
            an  <= AN_ACTIVE_LOW  ? ~sel    : sel;
            cat <= CAT_ACTIVE_LOW ? ~seg_hi : seg_hi;
        end
    end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n at DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, active-low outputs.
module tb_seg7_scan_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lzb;
    logic [3:0]  an;
    logic [7:0]  cat;
    logic        frame;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned onehot_viol = 0;

    seg7_scan_n #(
        .DIGITS         (4),
        .CLK_DIV        (8),
        .BLANK_CYCLES   (2),
        .AN_ACTIVE_LOW  (1'b1),
        .CAT_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .dp       (dp),
        .digit_en (digit_en),
        .lzb      (lzb),
        .an       (an),
        .cat      (cat),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(~an) > 1) onehot_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after posedge number p (counted from reset release).
    task automatic goto(input int unsigned p);
        while (cyc < p) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    // Observation point for frame f, digit d, slot cycle c (outputs lag state by one clk).
    function automatic int unsigned obs(input int unsigned f, input int unsigned d, input int unsigned c);
        return 32*f + 8*d + c + 1;
    endfunction

    task automatic check_out(input string tag, input int unsigned p,
                             input logic [3:0] exp_an, input logic [7:0] exp_cat);
        goto(p);
        check({tag, "_an"}, 32'(an), 32'(exp_an));
        check({tag, "_cat"}, 32'(cat), 32'(exp_cat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        value    = 16'h12AF;
        dp       = 4'b0000;
        digit_en = 4'hF;
        lzb      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_cat", 32'(cat), 32'h000000FF);
        check("rst_frame", 32'(frame), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // Frame 0 runs from the reset shadow: digits selected but dark.
        check_out("f0_blank", obs(0, 0, 0), 4'hF, 8'hFF);
        check_out("f0_d0", obs(0, 0, 2), 4'hE, 8'hFF);
        check_out("f0_d3", obs(0, 3, 5), 4'h7, 8'hFF);
        goto(31);
        check("frame_pre", 32'(frame), 32'h0);
        goto(32);
        check("frame_pulse", 32'(frame), 32'h1);
        goto(33);
        check("frame_post", 32'(frame), 32'h0);

        // Frame 1: 12AF, plain digits.
        check_out("f1_d0_blank0", obs(1, 0, 0), 4'hF, 8'hFF);
        check_out("f1_d0_blank1", obs(1, 0, 1), 4'hF, 8'hFF);
        check_out("f1_d0", obs(1, 0, 2), 4'hE, 8'h8E);
        check_out("f1_d0_end", obs(1, 0, 7), 4'hE, 8'h8E);
        check_out("f1_d1_blank", obs(1, 1, 1), 4'hF, 8'hFF);
        check_out("f1_d1", obs(1, 1, 2), 4'hD, 8'h88);
        // Mid-frame change must not show until the next frame.
        value = 16'h0070;
        lzb   = 1'b1;
        check_out("f1_d2_hold", obs(1, 2, 2), 4'hB, 8'hA4);
        check_out("f1_d3_hold", obs(1, 3, 4), 4'h7, 8'hF9);
        goto(64);
        check("frame_pulse2", 32'(frame), 32'h1);

        // Frame 2: 0070 with leading-zero blanking.
        check_out("f2_d0", obs(2, 0, 3), 4'hE, 8'hC0);
        check_out("f2_d1", obs(2, 1, 3), 4'hD, 8'hF8);
        value = 16'h0000;
        check_out("f2_d2_lzb", obs(2, 2, 3), 4'hB, 8'hFF);
        check_out("f2_d3_lzb", obs(2, 3, 3), 4'h7, 8'hFF);

        // Frame 3: all zero -> only digit 0 lit.
        check_out("f3_d0", obs(3, 0, 3), 4'hE, 8'hC0);
        check_out("f3_d1_lzb", obs(3, 1, 3), 4'hD, 8'hFF);
        value    = 16'h12AF;
        lzb      = 1'b0;
        dp       = 4'b0100;
        digit_en = 4'b1011;
        check_out("f3_d3_lzb", obs(3, 3, 3), 4'h7, 8'hFF);

        // Frame 4: digit 2 disabled, its dp suppressed too.
        check_out("f4_d0", obs(4, 0, 3), 4'hE, 8'h8E);
        check_out("f4_d1", obs(4, 1, 3), 4'hD, 8'h88);
        check_out("f4_d2_dis", obs(4, 2, 3), 4'hB, 8'hFF);
        dp       = 4'b0001;
        digit_en = 4'hF;
        check_out("f4_d3", obs(4, 3, 3), 4'h7, 8'hF9);

        // Frame 5: decimal point on digit 0 only.
        check_out("f5_d0_dp", obs(5, 0, 3), 4'hE, 8'h0E);
        check_out("f5_d1", obs(5, 1, 3), 4'hD, 8'h88);
        check_out("f5_d2", obs(5, 2, 3), 4'hB, 8'hA4);

        // Asynchronous reset in the middle of digit 2's slot.
        check_out("f6_d2", obs(6, 2, 3), 4'hB, 8'hA4);
        goto(obs(6, 2, 4));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'h0000000F);
        check("async_rst_cat", 32'(cat), 32'h000000FF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        check_out("post_rst_blank", obs(0, 0, 1), 4'hF, 8'hFF);
        check_out("post_rst_d0", obs(0, 0, 2), 4'hE, 8'hFF);
        check_out("post_rst_d1", obs(0, 1, 2), 4'hD, 8'hFF);
        goto(32);
        check("post_rst_frame", 32'(frame), 32'h1);
        check_out("post_rst_f1_d0", obs(1, 0, 2), 4'hE, 8'h0E);

        check("an_onehot", 32'(onehot_viol), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
